// File: rtl/vend_controller.sv
// vend_controller: vending transaction controller (coin credit, selection, dispense handshake, change return)
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   coin         per-cycle coin code: 00 none, 01 one unit, 10 two units, 11 invalid
//   sel_valid    one-cycle selection strobe, sel_id picks PRICE0/PRICE1
//   cancel       one-cycle refund request
//   disp_ack     dispenser completion acknowledge
//   disp_req     dispense request, held until ack or timeout; disp_id names the product
//   change_pulse one returned coin unit per high cycle
//   coin_reject  previous-cycle coin was returned rather than credited
//   sel_nack     selection refused for insufficient credit
//   credit       current credit in units
//   busy         high whenever not idle
//   fault        sticky dispense-timeout flag
module vend_controller #(
    parameter int PRICE0      = 3,
    parameter int PRICE1      = 4,
    parameter int CREDIT_MAX  = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic       sel_valid,
    input  logic       sel_id,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       disp_id,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       sel_nack,
    output logic [2:0] credit,
    output logic       busy,
    output logic       fault
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DISP = 2'd1;
    localparam logic [1:0] S_CHG  = 2'd2;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0] P0   = 4'(PRICE0);
    localparam logic [3:0] P1   = 4'(PRICE1);
    localparam logic [3:0] CMAX = 4'(CREDIT_MAX);
    // Last counter value before the timeout fires: disp_req is high for ACK_TIMEOUT cycles.
    localparam logic [CW-1:0] TLAST = CW'(ACK_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          disp_req_q, disp_req_d;
    logic          disp_id_q, disp_id_d;
    logic          change_q, change_d;
    logic          reject_q, reject_d;
    logic          nack_q, nack_d;
    logic          fault_q, fault_d;
    logic [3:0]    coin_val, sum, price_sel, price_disp;

    always_comb begin
        coin_val   = coin == 2'b01 ? 4'd1 : coin == 2'b10 ? 4'd2 : 4'd0;
        sum        = {1'b0, credit_q} + coin_val;
        price_sel  = sel_id ? P1 : P0;
        price_disp = disp_id_q ? P1 : P0;
        state_d    = state_q;
        credit_d   = credit_q;
        cnt_d      = cnt_q;
        disp_req_d = disp_req_q;
        disp_id_d  = disp_id_q;
        change_d   = 1'b0;
        reject_d   = 1'b0;
        nack_d     = 1'b0;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (cancel && credit_q != 3'd0) begin
                    state_d  = S_CHG;
                    reject_d = coin != 2'b00;
                end else if (sel_valid && {1'b0, credit_q} >= price_sel) begin
                    credit_d   = 3'({1'b0, credit_q} - price_sel);
                    disp_id_d  = sel_id;
                    disp_req_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DISP;
                    reject_d   = coin != 2'b00;
                end else begin
                    // A refused selection still lets a same-cycle coin through.
                    nack_d = sel_valid;
                    if (coin == 2'b11 || (coin_val != 4'd0 && sum > CMAX))
                        reject_d = 1'b1;
                    else
                        credit_d = sum[2:0];
                end
            end
            S_DISP: begin
                reject_d = coin != 2'b00;
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    state_d    = credit_q != 3'd0 ? S_CHG : S_IDLE;
                end else if (cnt_q == TLAST) begin
                    // Refund the price; the sum cannot exceed the credit held before the sale.
                    disp_req_d = 1'b0;
                    credit_d   = 3'({1'b0, credit_q} + price_disp);
                    fault_d    = 1'b1;
                    state_d    = S_CHG;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHG: begin
                reject_d = coin != 2'b00;
                change_d = credit_q != 3'd0;
                credit_d = credit_q - 3'(change_d);
                state_d  = credit_q <= 3'd1 ? S_IDLE : S_CHG;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            cnt_q      <= '0;
            disp_req_q <= 1'b0;
            disp_id_q  <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            nack_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            disp_req_q <= disp_req_d;
            disp_id_q  <= disp_id_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            nack_q     <= nack_d;
            fault_q    <= fault_d;
        end
    end

    assign disp_req     = disp_req_q;
    assign disp_id      = disp_id_q;
    assign change_pulse = change_q;
    assign coin_reject  = reject_q;
    assign sel_nack     = nack_q;
    assign credit       = credit_q;
    assign busy         = state_q != S_IDLE;
    assign fault        = fault_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed vector table plus timeout/fault sequences for vend_controller
module tb_vend_controller;
    localparam int TO = 15;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       sel_valid, sel_id, cancel, disp_ack;
    logic       disp_req, disp_id, change_pulse, coin_reject, sel_nack, busy, fault;
    logic [2:0] credit;
    logic [9:0] outv;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic [6:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[31];

    vend_controller #(.PRICE0(3), .PRICE1(4), .CREDIT_MAX(7), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .disp_ack(disp_ack), .disp_req(disp_req), .disp_id(disp_id),
        .change_pulse(change_pulse), .coin_reject(coin_reject), .sel_nack(sel_nack),
        .credit(credit), .busy(busy), .fault(fault)
    );

    assign outv = {disp_req, disp_id, change_pulse, coin_reject, sel_nack, credit, busy, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // in = {reset, coin[1:0], sel_valid, sel_id, cancel, disp_ack}
    task automatic apply(input logic [6:0] in);
        @(negedge clk);
        {reset, coin, sel_valid, sel_id, cancel, disp_ack} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    localparam logic [6:0] IDLE_IN = 7'b1_00_0000;

    initial begin
        {reset, coin, sel_valid, sel_id, cancel, disp_ack} = 7'b0_00_0000;
        // exp = {disp_req, disp_id, change_pulse, coin_reject, sel_nack, credit[2:0], busy, fault}
        tbl[0]  = '{7'b0_01_0000, 10'b0_0_0_0_0_000_0_0};
        tbl[1]  = '{7'b0_01_0000, 10'b0_0_0_0_0_000_0_0};
        tbl[2]  = '{7'b1_01_0000, 10'b0_0_0_0_0_001_0_0};
        tbl[3]  = '{7'b1_10_0000, 10'b0_0_0_0_0_011_0_0};
        tbl[4]  = '{7'b1_00_1000, 10'b1_0_0_0_0_000_1_0};
        tbl[5]  = '{7'b1_00_0000, 10'b1_0_0_0_0_000_1_0};
        tbl[6]  = '{7'b1_00_0000, 10'b1_0_0_0_0_000_1_0};
        tbl[7]  = '{7'b1_00_0001, 10'b0_0_0_0_0_000_0_0};
        tbl[8]  = '{7'b1_00_0000, 10'b0_0_0_0_0_000_0_0};
        tbl[9]  = '{7'b1_10_0000, 10'b0_0_0_0_0_010_0_0};
        tbl[10] = '{7'b1_10_0000, 10'b0_0_0_0_0_100_0_0};
        tbl[11] = '{7'b1_10_0000, 10'b0_0_0_0_0_110_0_0};
        tbl[12] = '{7'b1_10_0000, 10'b0_0_0_1_0_110_0_0};
        tbl[13] = '{7'b1_11_0000, 10'b0_0_0_1_0_110_0_0};
        tbl[14] = '{7'b1_00_1100, 10'b1_1_0_0_0_010_1_0};
        tbl[15] = '{7'b1_01_0000, 10'b1_1_0_1_0_010_1_0};
        tbl[16] = '{7'b1_00_1110, 10'b1_1_0_0_0_010_1_0};
        tbl[17] = '{7'b1_00_0001, 10'b0_1_0_0_0_010_1_0};
        tbl[18] = '{7'b1_00_0000, 10'b0_1_1_0_0_001_1_0};
        tbl[19] = '{7'b1_00_0000, 10'b0_1_1_0_0_000_0_0};
        tbl[20] = '{7'b1_00_0000, 10'b0_1_0_0_0_000_0_0};
        tbl[21] = '{7'b1_10_0000, 10'b0_1_0_0_0_010_0_0};
        tbl[22] = '{7'b1_01_1100, 10'b0_1_0_0_1_011_0_0};
        tbl[23] = '{7'b1_10_0000, 10'b0_1_0_0_0_101_0_0};
        tbl[24] = '{7'b1_10_1010, 10'b0_1_0_1_0_101_1_0};
        tbl[25] = '{7'b1_00_0000, 10'b0_1_1_0_0_100_1_0};
        tbl[26] = '{7'b1_01_0000, 10'b0_1_1_1_0_011_1_0};
        tbl[27] = '{7'b1_00_0000, 10'b0_1_1_0_0_010_1_0};
        tbl[28] = '{7'b1_00_0000, 10'b0_1_1_0_0_001_1_0};
        tbl[29] = '{7'b1_00_0000, 10'b0_1_1_0_0_000_0_0};
        tbl[30] = '{7'b1_00_0001, 10'b0_1_0_0_0_000_0_0};

        for (int i = 0; i < 31; i++) begin
            apply(tbl[i].in);
            checks++;
            if (outv !== tbl[i].exp) begin
                failures++;
                $display("FAIL vec%0d: got %b expected %b", i, outv, tbl[i].exp);
            end
        end

        apply(7'b1_10_0000);
        apply(7'b1_10_0000);
        chk("to_credit4", credit, 4);
        apply(7'b1_00_1000);
        chk("to_req", disp_req, 1);
        chk("to_id", disp_id, 0);
        chk("to_credit1", credit, 1);
        for (int i = 1; i < TO; i++) begin
            apply(IDLE_IN);
            chk($sformatf("to_hold%0d", i), disp_req, 1);
        end
        apply(IDLE_IN);
        chk("to_req_drop", disp_req, 0);
        chk("to_fault", fault, 1);
        chk("to_refund", credit, 4);
        chk("to_busy", busy, 1);
        for (int k = 3; k >= 0; k--) begin
            apply(IDLE_IN);
            chk($sformatf("to_pulse%0d", k), change_pulse, 1);
            chk($sformatf("to_cred%0d", k), credit, k);
        end
        chk("to_busy_end", busy, 0);
        apply(IDLE_IN);
        chk("to_pulse_end", change_pulse, 0);
        chk("to_fault_sticky", fault, 1);

        apply(7'b1_10_0000);
        apply(7'b1_01_0000);
        apply(7'b1_00_1000);
        chk("post_fault_req", disp_req, 1);
        apply(7'b1_00_0001);
        chk("post_fault_done", disp_req, 0);
        chk("post_fault_busy", busy, 0);
        chk("post_fault_flag", fault, 1);

        apply(7'b0_00_0000);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        apply(7'b1_01_0000);
        chk("rst_coin", credit, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction controller for the coin-operated vending datapath.
- Accumulates coin credit and accepts a two-product selection.
- Drives the dispense mechanism over a req/ack handshake, with a timeout, and returns change one unit per pulse.
- Sits between the coin acceptor front-end and the dispense/change actuators. Sequences all actuator activity, so only one transaction is in flight at a time.

Parameters:
- PRICE0, 3, price of product 0 in coin units (1..CREDIT_MAX).
- PRICE1, 4, price of product 1 in coin units (1..CREDIT_MAX).
- CREDIT_MAX, 7, saturation limit of the credit register; must fit in 3 bits.
- ACK_TIMEOUT, 15, cycles DISPENSE waits for disp_ack before aborting; must be at least 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- coin  in  2  per-cycle coin code: 00 none, 01 one unit, 10 two units, 11 invalid (treated as a rejected coin)
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  1  product select: 0 uses PRICE0, 1 uses PRICE1
- cancel  in  1  one-cycle request to refund all credit
- disp_ack  in  1  dispenser completion acknowledge
- disp_req  out  1  dispense request, held until acknowledged
- disp_id  out  1  product being dispensed, stable while disp_req=1
- change_pulse  out  1  one coin unit returned per high cycle
- coin_reject  out  1  one-cycle pulse: the coin in the previous cycle was returned, not credited
- sel_nack  out  1  one-cycle pulse: selection refused for insufficient credit
- credit  out  3  current credit in units
- busy  out  1  high whenever state != IDLE
- fault  out  1  sticky dispense-timeout flag

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE.
  - credit, disp_req, disp_id, change_pulse, coin_reject, sel_nack, fault, busy all 0.
  - Timeout counter cleared.
  - Reset asserted mid-DISPENSE or mid-CHANGE abandons the transaction; credit is lost.
- Registered outputs: all outputs are registered. Every response appears on the cycle after the sampling edge.
- States: IDLE, DISPENSE, CHANGE.
- IDLE, priority per cycle is cancel > selection > coin.
  - cancel=1, credit>0: go to CHANGE. cancel=1, credit=0: no effect. A coin in the same cycle is rejected.
  - sel_valid=1 and credit >= price(sel_id):
    - credit <= credit - price; disp_id <= sel_id; disp_req <= 1; go to DISPENSE.
    - A same-cycle coin is rejected.
  - sel_valid=1 and credit < price: sel_nack pulse. A same-cycle coin is still processed as below.
  - Coin value v (01→1, 10→2):
    - credit+v <= CREDIT_MAX: credit += v.
    - Otherwise credit is unchanged and coin_reject pulses.
    - coin=11 always pulses coin_reject.
- DISPENSE:
  - disp_req stays 1; the timeout counter increments each cycle.
  - disp_ack=1 sampled:
    - disp_req <= 0.
    - Go to CHANGE if the remaining credit > 0, else IDLE.
  - Counter reaches ACK_TIMEOUT with no ack:
    - disp_req <= 0; credit <= credit + price(disp_id), the refund.
    - fault <= 1; go to CHANGE.
  - Coins are rejected; cancel and sel_valid are ignored.
  - disp_ack while not in DISPENSE is ignored.
- CHANGE:
  - change_pulse=1 for one cycle per unit, back-to-back, and credit decrements once per pulse.
  - Go to IDLE on the cycle credit becomes 0.
  - Coins are rejected; cancel and sel are ignored.
- fault: cleared only by reset. It does not block later transactions.
- Credit arithmetic: unsigned 3-bit and never wraps. Overflow is prevented by rejection; underflow is impossible by construction.

Test Plan:
- Reset: hold reset=0 for 2 cycles with coin=01 -> credit=0, all outputs 0; release -> the first 01 coin gives credit=1 one cycle later.
- Exact purchase: coins 01,10 (credit=3), then sel_valid with sel_id=0 -> disp_req=1, disp_id=0, credit=0; ack after 3 cycles -> disp_req=0, state IDLE, no change_pulse.
- Purchase with change: coins 10,10,10 (credit=6), then sel_id=1 -> credit=2; on ack, two consecutive change_pulse cycles, credit 2→1→0, busy then drops.
- Saturation and rejection:
  - credit=6 plus coin 10 -> coin_reject=1, credit stays 6.
  - coin=11 -> coin_reject.
  - A coin during DISPENSE -> coin_reject.
- Insufficient credit and same-cycle events:
  - credit=2, sel_id=1 with coin 01 in the same cycle -> sel_nack=1, credit=3.
  - credit=5, cancel and sel in the same cycle -> 5 change_pulses, no disp_req.
- Timeout: credit=4, sel_id=0, disp_ack held 0 -> after ACK_TIMEOUT cycles, disp_req=0 and fault=1; 4 change_pulses follow; fault stays 1 until reset.
